max2ccx_endpoint: RTL and testbench

//  Far-end counterpart of the SPARC-side CCX/Maxeler bridge. Deframes the 32-bit
//  PCX word stream into whole PCX packets for the memory/L2 model. Frames whole
//  CPX return packets into 32-bit words plus control words. Those words are held
//  in a show-ahead word FIFO that the bridge drains with read/empty/almost_empty.

---
 rtl/max2ccx_endpoint.sv | 229 ++++++++++++++++++++++
 tb/tb_max2ccx_endpoint.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max2ccx_endpoint.sv
// -----------------------------------------------------------------------------
// max2ccx_endpoint
//
// Far-end partner of the SPARC-side CCX/Maxeler bridge.
//  * PCX direction: deframes a stream of 32-bit words (header + 4 data words)
//    into whole 124-bit PCX packets with valid/ready hand-off to the L2 model.
//  * CPX direction: splits whole 145-bit CPX packets into five 32-bit words,
//    each with a control word, and queues them in a show-ahead FIFO that the
//    bridge drains with cpx_read / cpx_empty / cpx_almost_empty.
//
// Ports
//  gclk, reset          clock, synchronous active-high reset
//  pcx_word_valid/data  incoming PCX word stream
//  pcx_word_stall       backpressure to the PCX word source
//  pcx_pkt_*            assembled PCX packet (valid held until ready)
//  cpx_pkt_valid/data   offered CPX packet; cpx_pkt_ready pulses on acceptance
//  cpx_word_data/ctl    FIFO head (zero while empty)
//  cpx_empty            FIFO empty
//  cpx_almost_empty     FIFO occupancy <= AE_THRESH
//  cpx_read             pop FIFO head (ignored while empty)
// -----------------------------------------------------------------------------
module max2ccx_endpoint #(
    parameter int CPX_FIFO_DEPTH = 16,
    parameter int AE_THRESH      = 4
) (
    input  logic         gclk,
    input  logic         reset,
    input  logic         pcx_word_valid,
    input  logic [31:0]  pcx_word_data,
    output logic         pcx_word_stall,
    output logic         pcx_pkt_valid,
    output logic [123:0] pcx_pkt_data,
    output logic         pcx_pkt_atom,
    output logic [4:0]   pcx_pkt_req,
    input  logic         pcx_pkt_ready,
    input  logic         cpx_pkt_valid,
    input  logic [144:0] cpx_pkt_data,
    output logic         cpx_pkt_ready,
    output logic [31:0]  cpx_word_data,
    output logic [31:0]  cpx_word_ctl,
    output logic         cpx_empty,
    output logic         cpx_almost_empty,
    input  logic         cpx_read
);

    localparam int AW = $clog2(CPX_FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Highest occupancy that still leaves room for a whole 5-word frame.
    localparam logic [CW-1:0] FRAME_ROOM = CW'(CPX_FIFO_DEPTH - 5);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_THRESH);

    typedef enum logic [2:0] {PCX_HDR, PCX_D0, PCX_D1, PCX_D2, PCX_D3} pcx_state_t;
    typedef enum logic [2:0] {CPX_IDLE, CPX_W0, CPX_W1, CPX_W2, CPX_W3, CPX_W4} cpx_state_t;

    // ---------------------------------------------------------------- PCX side
    pcx_state_t     r_pcx_state;
    logic [4:0]     r_hdr_req;
    logic           r_hdr_atom;
    logic [27:0]    r_d0;
    logic [31:0]    r_d1;
    logic [31:0]    r_d2;
    logic           r_pcx_pkt_valid;
    logic [123:0]   r_pcx_pkt_data;
    logic           r_pcx_pkt_atom;
    logic [4:0]     r_pcx_pkt_req;
    logic           w_pcx_take;

    // Stall only while an unaccepted packet is held; a header can therefore
    // be taken in the same cycle the previous packet is accepted.
    assign pcx_word_stall = r_pcx_pkt_valid && !pcx_pkt_ready;
    assign w_pcx_take     = pcx_word_valid && !pcx_word_stall;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge gclk) begin
        if (reset) begin
            r_pcx_state     <= PCX_HDR;
            r_hdr_req       <= '0;
            r_hdr_atom      <= 1'b0;
            r_d0            <= '0;
            r_d1            <= '0;
            r_d2            <= '0;
            r_pcx_pkt_valid <= 1'b0;
            r_pcx_pkt_data  <= '0;
            r_pcx_pkt_atom  <= 1'b0;
            r_pcx_pkt_req   <= '0;
        end else begin
            if (r_pcx_pkt_valid && pcx_pkt_ready)
                r_pcx_pkt_valid <= 1'b0;
            if (w_pcx_take) begin
                case (r_pcx_state)
                    PCX_HDR: begin
                        r_hdr_req   <= pcx_word_data[4:0];
                        r_hdr_atom  <= pcx_word_data[5];
                        r_pcx_state <= PCX_D0;
                    end
                    PCX_D0: begin
                        r_d0        <= pcx_word_data[27:0];
                        r_pcx_state <= PCX_D1;
                    end
                    PCX_D1: begin
                        r_d1        <= pcx_word_data;
                        r_pcx_state <= PCX_D2;
                    end
                    PCX_D2: begin
                        r_d2        <= pcx_word_data;
                        r_pcx_state <= PCX_D3;
                    end
                    PCX_D3: begin
                        // Overrides the clear above if the old packet leaves this cycle.
                        r_pcx_pkt_valid <= 1'b1;
                        r_pcx_pkt_data  <= {r_d0, r_d1, r_d2, pcx_word_data};
                        r_pcx_pkt_atom  <= r_hdr_atom;
                        r_pcx_pkt_req   <= r_hdr_req;
                        r_pcx_state     <= PCX_HDR;
                    end
                    default: r_pcx_state <= PCX_HDR;
                endcase
            end
        end
    end

    assign pcx_pkt_valid = r_pcx_pkt_valid;
    assign pcx_pkt_data  = r_pcx_pkt_data;
    assign pcx_pkt_atom  = r_pcx_pkt_atom;
    assign pcx_pkt_req   = r_pcx_pkt_req;

    // ---------------------------------------------------------------- CPX side
    cpx_state_t     r_cpx_state;
    logic [144:0]   r_cpx_pkt;
    logic           r_cpx_pkt_ready;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_cpx_empty;
    logic           r_cpx_almost_empty;
    logic [31:0]    r_mem_data [CPX_FIFO_DEPTH];
    logic [1:0]     r_mem_ctl  [CPX_FIFO_DEPTH];   // {cpx[144], first-word}

    logic           w_push;
    logic           w_push_first;
    logic [31:0]    w_push_data;
    logic           w_pop;
    logic [CW-1:0]  w_count_next;

    // Framer: accept only when a whole frame fits, so pushes never meet full.
    always_ff @(posedge gclk) begin
        if (reset) begin
            r_cpx_state     <= CPX_IDLE;
            r_cpx_pkt       <= '0;
            r_cpx_pkt_ready <= 1'b0;
        end else begin
            r_cpx_pkt_ready <= 1'b0;
            case (r_cpx_state)
                CPX_IDLE: begin
                    if (cpx_pkt_valid && (r_count <= FRAME_ROOM)) begin
                        r_cpx_pkt       <= cpx_pkt_data;
                        r_cpx_pkt_ready <= 1'b1;
                        r_cpx_state     <= CPX_W0;
                    end
                end
                CPX_W0:  r_cpx_state <= CPX_W1;
                CPX_W1:  r_cpx_state <= CPX_W2;
                CPX_W2:  r_cpx_state <= CPX_W3;
                CPX_W3:  r_cpx_state <= CPX_W4;
                default: r_cpx_state <= CPX_IDLE;
            endcase
        end
    end

    assign cpx_pkt_ready = r_cpx_pkt_ready;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_push       = 1'b1;
        w_push_first = 1'b0;
        w_push_data  = '0;
        case (r_cpx_state)
            CPX_W0: begin
                w_push_data  = {15'b0, r_cpx_pkt[144:128]};
                w_push_first = 1'b1;
            end
            CPX_W1:  w_push_data = r_cpx_pkt[127:96];
            CPX_W2:  w_push_data = r_cpx_pkt[95:64];
            CPX_W3:  w_push_data = r_cpx_pkt[63:32];
            CPX_W4:  w_push_data = r_cpx_pkt[31:0];
            default: w_push      = 1'b0;
        endcase
    end

    assign w_pop        = cpx_read && !r_cpx_empty;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // NOTE: the storage array has no reset; the pointers and count alone
    // decide which entries are valid, and the head is masked while empty.
    always_ff @(posedge gclk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_ctl[r_wr_ptr]  <= {r_cpx_pkt[144], w_push_first};
        end
    end

    // Flags come from the next-state count so they line up with the head.
    always_ff @(posedge gclk) begin
        if (reset) begin
            r_wr_ptr           <= '0;
            r_rd_ptr           <= '0;
            r_count            <= '0;
            r_cpx_empty        <= 1'b1;
            r_cpx_almost_empty <= 1'b1;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count            <= w_count_next;
            r_cpx_empty        <= (w_count_next == '0);
            r_cpx_almost_empty <= (w_count_next <= AE_LEVEL);
        end
    end

    assign cpx_empty        = r_cpx_empty;
    assign cpx_almost_empty = r_cpx_almost_empty;
    assign cpx_word_data    = r_cpx_empty ? 32'h0 : r_mem_data[r_rd_ptr];
    assign cpx_word_ctl     = r_cpx_empty ? 32'h0
                            : {27'b0, r_mem_ctl[r_rd_ptr][1], r_mem_ctl[r_rd_ptr][0], 3'b0};

endmodule

// File: tb/tb_max2ccx_endpoint.sv
// -----------------------------------------------------------------------------
// tb_max2ccx_endpoint
//
// Directed bench for max2ccx_endpoint: PCX deframing with and without
// backpressure, CPX framing, FIFO fill/drain with flag boundaries, and reset
// in the middle of both a PCX frame and a CPX frame.
// Inputs change right after a rising edge or on a falling edge; outputs are
// sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_max2ccx_endpoint;

    logic         gclk;
    logic         reset;
    logic         pcx_word_valid;
    logic [31:0]  pcx_word_data;
    logic         pcx_word_stall;
    logic         pcx_pkt_valid;
    logic [123:0] pcx_pkt_data;
    logic         pcx_pkt_atom;
    logic [4:0]   pcx_pkt_req;
    logic         pcx_pkt_ready;
    logic         cpx_pkt_valid;
    logic [144:0] cpx_pkt_data;
    logic         cpx_pkt_ready;
    logic [31:0]  cpx_word_data;
    logic [31:0]  cpx_word_ctl;
    logic         cpx_empty;
    logic         cpx_almost_empty;
    logic         cpx_read;

    int n_checks = 0;
    int n_errors = 0;

    max2ccx_endpoint #(.CPX_FIFO_DEPTH(16), .AE_THRESH(4)) dut (
        .gclk             (gclk),
        .reset            (reset),
        .pcx_word_valid   (pcx_word_valid),
        .pcx_word_data    (pcx_word_data),
        .pcx_word_stall   (pcx_word_stall),
        .pcx_pkt_valid    (pcx_pkt_valid),
        .pcx_pkt_data     (pcx_pkt_data),
        .pcx_pkt_atom     (pcx_pkt_atom),
        .pcx_pkt_req      (pcx_pkt_req),
        .pcx_pkt_ready    (pcx_pkt_ready),
        .cpx_pkt_valid    (cpx_pkt_valid),
        .cpx_pkt_data     (cpx_pkt_data),
        .cpx_pkt_ready    (cpx_pkt_ready),
        .cpx_word_data    (cpx_word_data),
        .cpx_word_ctl     (cpx_word_ctl),
        .cpx_empty        (cpx_empty),
        .cpx_almost_empty (cpx_almost_empty),
        .cpx_read         (cpx_read)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the word.
    task automatic send_pcx(input logic [31:0] w);
        int n;
        n = 0;
        pcx_word_valid = 1'b1;
        pcx_word_data  = w;
        @(negedge gclk);
        while (pcx_word_stall && n < 50) begin
            n++;
            @(negedge gclk);
        end
        if (n >= 50) check("pcx_take_timeout", 1'b1, 1'b0);
        @(posedge gclk);
        #1;
        pcx_word_valid = 1'b0;
    endtask

    // Called on a falling edge; offers a packet for up to 'budget' cycles.
    task automatic offer_cpx(input logic [144:0] pkt, input int budget, output logic acc);
        acc = 1'b0;
        cpx_pkt_valid = 1'b1;
        cpx_pkt_data  = pkt;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge gclk);
            if (cpx_pkt_ready) acc = 1'b1;
        end
        if (acc) cpx_pkt_valid = 1'b0;
    endtask

    function automatic logic [31:0] exp_word(input logic [144:0] p, input int i);
        case (i)
            0:       return {15'b0, p[144:128]};
            1:       return p[127:96];
            2:       return p[95:64];
            3:       return p[63:32];
            default: return p[31:0];
        endcase
    endfunction

    function automatic logic [31:0] exp_ctl(input logic [144:0] p, input int i);
        return {27'b0, p[144], (i == 0), 3'b0};
    endfunction

    logic [144:0] pk [6];
    logic [31:0]  exp_d [16];
    logic [31:0]  exp_c [16];
    logic [31:0]  got_d [5];
    logic [31:0]  got_c [5];

    initial begin
        logic acc;
        int   n;
        int   rdy_cnt;
        int   cyc;

        reset          = 1'b1;
        pcx_word_valid = 1'b0;
        pcx_word_data  = '0;
        pcx_pkt_ready  = 1'b0;
        cpx_pkt_valid  = 1'b0;
        cpx_pkt_data   = '0;
        cpx_read       = 1'b0;

        pk[0] = {1'b1, 16'hA001, 32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004};
        pk[1] = {1'b0, 16'hA002, 32'h20000001, 32'h20000002, 32'h20000003, 32'h20000004};
        pk[2] = {1'b1, 16'hA003, 32'h30000001, 32'h30000002, 32'h30000003, 32'h30000004};
        pk[3] = {1'b0, 16'hA004, 32'h40000001, 32'h40000002, 32'h40000003, 32'h40000004};
        pk[4] = {1'b1, 16'hBEEF, 32'h50000001, 32'h50000002, 32'h50000003, 32'h50000004};
        pk[5] = {1'b0, 16'hC0DE, 32'h60000001, 32'h60000002, 32'h60000003, 32'h60000004};

        repeat (3) @(posedge gclk);
        #1 reset = 1'b0;

        // ---- reset state
        @(negedge gclk);
        check("rst_pkt_valid", pcx_pkt_valid, 1'b0);
        check("rst_pkt_data",  pcx_pkt_data, 124'h0);
        check("rst_stall",     pcx_word_stall, 1'b0);
        check("rst_cpx_ready", cpx_pkt_ready, 1'b0);
        check("rst_word_data", cpx_word_data, 32'h0);
        check("rst_word_ctl",  cpx_word_ctl, 32'h0);
        check("rst_empty",     cpx_empty, 1'b1);
        check("rst_ae",        cpx_almost_empty, 1'b1);

        // ---- 1: basic PCX frame
        pcx_pkt_ready = 1'b1;
        @(posedge gclk); #1;
        send_pcx(32'h00000021);
        send_pcx(32'h0ABCDEF0);
        send_pcx(32'h11111111);
        send_pcx(32'h22222222);
        send_pcx(32'h33333333);
        @(negedge gclk);
        check("p1_valid", pcx_pkt_valid, 1'b1);
        check("p1_req",   pcx_pkt_req, 5'h01);
        check("p1_atom",  pcx_pkt_atom, 1'b1);
        check("p1_data",  pcx_pkt_data, 124'hABCDEF0_11111111_22222222_33333333);
        @(negedge gclk);
        check("p1_consumed", pcx_pkt_valid, 1'b0);

        // ---- 2: PCX backpressure, header offered while the old packet waits
        @(posedge gclk); #1;
        pcx_pkt_ready = 1'b0;
        send_pcx(32'h00000012);
        send_pcx(32'hF1234567);
        send_pcx(32'h89ABCDEF);
        send_pcx(32'h13579BDF);
        send_pcx(32'h2468ACE0);
        pcx_word_valid = 1'b1;
        pcx_word_data  = 32'hFFFFFFEA;
        for (int i = 0; i < 3; i++) begin
            @(negedge gclk);
            check("p2_stall", pcx_word_stall, 1'b1);
            check("p2_hold_valid", pcx_pkt_valid, 1'b1);
            check("p2_hold_data", pcx_pkt_data, 124'h1234567_89ABCDEF_13579BDF_2468ACE0);
        end
        check("p2_req",  pcx_pkt_req, 5'h12);
        check("p2_atom", pcx_pkt_atom, 1'b0);
        @(posedge gclk); #1;
        pcx_pkt_ready = 1'b1;
        send_pcx(32'hFFFFFFEA);
        @(negedge gclk);
        check("p3_gap_valid", pcx_pkt_valid, 1'b0);
        @(posedge gclk); #1;
        send_pcx(32'hA7654321);
        send_pcx(32'hDEADBEEF);
        send_pcx(32'hCAFEF00D);
        send_pcx(32'h0BADC0DE);
        @(negedge gclk);
        check("p3_valid", pcx_pkt_valid, 1'b1);
        check("p3_req",   pcx_pkt_req, 5'h0A);
        check("p3_atom",  pcx_pkt_atom, 1'b1);
        check("p3_data",  pcx_pkt_data, 124'h7654321_DEADBEEF_CAFEF00D_0BADC0DE);

        // ---- 3: CPX framing with continuous read
        @(negedge gclk);
        cpx_read      = 1'b1;
        cpx_pkt_valid = 1'b1;
        cpx_pkt_data  = {1'b1, 16'h1234, 32'hA, 32'hB, 32'hC, 32'hD};
        n = 0;
        rdy_cnt = 0;
        cyc = 0;
        while (n < 5 && cyc < 30) begin
            @(negedge gclk);
            cyc++;
            if (cpx_pkt_ready) begin
                rdy_cnt++;
                cpx_pkt_valid = 1'b0;
            end
            if (!cpx_empty) begin
                got_d[n] = cpx_word_data;
                got_c[n] = cpx_word_ctl;
                n++;
            end
        end
        check("c1_words_seen", n, 5);
        check("c1_ready_pulses", rdy_cnt, 1);
        check("c1_w0_data", got_d[0], 32'h00011234);
        check("c1_w0_ctl",  got_c[0], 32'h18);
        check("c1_w1_data", got_d[1], 32'hA);
        check("c1_w1_ctl",  got_c[1], 32'h10);
        check("c1_w2_data", got_d[2], 32'hB);
        check("c1_w3_data", got_d[3], 32'hC);
        check("c1_w4_data", got_d[4], 32'hD);
        check("c1_w4_ctl",  got_c[4], 32'h10);
        @(negedge gclk);
        check("c1_drained", cpx_empty, 1'b1);
        cpx_read = 1'b0;

        // ---- 4: FIFO fill, 4th packet blocked until 5 entries are free
        for (int k = 0; k < 3; k++) begin
            offer_cpx(pk[k], 20, acc);
            check("fill_accept", acc, 1'b1);
        end
        offer_cpx(pk[3], 12, acc);
        check("fill_4th_blocked", acc, 1'b0);
        check("fill_15_ae", cpx_almost_empty, 1'b0);
        cpx_read = 1'b1;
        @(negedge gclk);
        cpx_read = 1'b0;
        offer_cpx(pk[3], 6, acc);
        check("fill_4th_blocked_after_1pop", acc, 1'b0);
        cpx_read = 1'b1;
        repeat (3) @(negedge gclk);
        cpx_read = 1'b0;
        offer_cpx(pk[3], 6, acc);
        check("fill_4th_accepted_after_4pops", acc, 1'b1);
        repeat (6) @(negedge gclk);

        // ---- 5: drain 16 -> 0 checking order and flags, then pop on empty
        exp_d[0] = exp_word(pk[0], 4);
        exp_c[0] = exp_ctl(pk[0], 4);
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < 5; i++) begin
                exp_d[1 + (k - 1) * 5 + i] = exp_word(pk[k], i);
                exp_c[1 + (k - 1) * 5 + i] = exp_ctl(pk[k], i);
            end
        end
        cpx_read = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("drain_data",  cpx_word_data, exp_d[k]);
            check("drain_ctl",   cpx_word_ctl, exp_c[k]);
            check("drain_empty", cpx_empty, 1'b0);
            check("drain_ae",    cpx_almost_empty, ((16 - k) <= 4));
            @(negedge gclk);
        end
        check("drained_empty", cpx_empty, 1'b1);
        check("drained_ae",    cpx_almost_empty, 1'b1);
        repeat (2) @(negedge gclk);
        check("pop_on_empty_empty", cpx_empty, 1'b1);
        cpx_read = 1'b0;
        offer_cpx(pk[4], 10, acc);
        check("after_empty_accept", acc, 1'b1);
        repeat (6) @(negedge gclk);
        check("five_words_empty", cpx_empty, 1'b0);
        check("five_words_ae",    cpx_almost_empty, 1'b0);
        check("five_words_head",  cpx_word_data, 32'h0001BEEF);
        check("five_words_ctl",   cpx_word_ctl, 32'h18);

        // ---- 6: reset mid PCX frame and mid CPX frame
        @(posedge gclk); #1;
        send_pcx(32'h0000003F);
        send_pcx(32'h09999999);
        send_pcx(32'hAAAAAAAA);
        @(negedge gclk);
        offer_cpx(pk[5], 20, acc);
        check("rst6_cpx_accept", acc, 1'b1);
        repeat (2) @(negedge gclk);
        reset = 1'b1;
        @(negedge gclk);
        reset = 1'b0;
        check("rst6_pkt_valid", pcx_pkt_valid, 1'b0);
        check("rst6_empty",     cpx_empty, 1'b1);
        check("rst6_ae",        cpx_almost_empty, 1'b1);
        check("rst6_cpx_ready", cpx_pkt_ready, 1'b0);
        repeat (4) @(negedge gclk);
        check("rst6_still_empty", cpx_empty, 1'b1);
        check("rst6_no_pkt",      pcx_pkt_valid, 1'b0);
        @(posedge gclk); #1;
        send_pcx(32'h00000007);
        send_pcx(32'h05555555);
        send_pcx(32'h66666666);
        send_pcx(32'h77777777);
        @(negedge gclk);
        check("rst6_no_early_pkt", pcx_pkt_valid, 1'b0);
        @(posedge gclk); #1;
        send_pcx(32'h88888888);
        @(negedge gclk);
        check("p4_valid", pcx_pkt_valid, 1'b1);
        check("p4_req",   pcx_pkt_req, 5'h07);
        check("p4_atom",  pcx_pkt_atom, 1'b0);
        check("p4_data",  pcx_pkt_data, 124'h5555555_66666666_77777777_88888888);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
